shift_sequencer: RTL and testbench

Multi-cycle shift unit controller. It accepts one shift request at a time through a start/ready handshake. It then applies the log-shifter stages (16, 8, 4, 2, 1) one per clock, each stage gated by the matching shamt bit, and presents a registered 32-bit result with a one-cycle valid pulse. It sits in the execute stage beside the ALU and is used by the pipeline control for SLL/SRA when single-cycle shifting is disabled to meet timing.

---
 rtl/shift_sequencer_pkg.sv | 14 +
 rtl/shift_sequencer_shift_stage.sv | 40 ++++
 rtl/shift_sequencer.sv | 84 ++++++++
 tb/tb_shift_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared constants and state encoding for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

  localparam logic        OP_SLL       = 1'b0;
  localparam logic        OP_SRA       = 1'b1;
  localparam int unsigned SHIFT_STAGES = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shift_stage.sv
// One log-shifter stage: shift by 2^k left (zero fill) or arithmetic right when en is set.
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [31:0] x,
  input  logic        op,
  input  logic [2:0]  k,
  input  logic        en,
  output logic [31:0] y
);

  logic [31:0] shifted;
  logic        fill;

  always_comb begin
    fill = (op == OP_SRA) ? x[31] : 1'b0;
    shifted = x;
    if (op == OP_SRA) begin
      case (k)
        3'd0:    shifted = {{1{fill}},  x[31:1]};
        3'd1:    shifted = {{2{fill}},  x[31:2]};
        3'd2:    shifted = {{4{fill}},  x[31:4]};
        3'd3:    shifted = {{8{fill}},  x[31:8]};
        3'd4:    shifted = {{16{fill}}, x[31:16]};
        default: shifted = x;
      endcase
    end else begin
      case (k)
        3'd0:    shifted = {x[30:0], 1'b0};
        3'd1:    shifted = {x[29:0], 2'b0};
        3'd2:    shifted = {x[27:0], 4'b0};
        3'd3:    shifted = {x[23:0], 8'b0};
        3'd4:    shifted = {x[15:0], 16'b0};
        default: shifted = x;
      endcase
    end
    y = en ? shifted : x;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA unit: accepts a request in idle, runs stages 16/8/4/2/1, pulses result_valid.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = SHIFT_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ctrl_op,
  input  logic [4:0]       ctrl_shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] KTop = 3'(STAGES - 1);

  state_e           state;
  logic [2:0]       k;
  logic             op_q;
  logic [4:0]       shamt_q;
  logic [WIDTH-1:0] acc;
  logic [31:0]      stage_y;

  shift_stage u_stage (
    .x  (acc),
    .op (op_q),
    .k  (k),
    .en (shamt_q[k]),
    .y  (stage_y)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      k            <= KTop;
      op_q         <= 1'b0;
      shamt_q      <= 5'd0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ready        <= 1'b1;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          result_valid <= 1'b0;
          if (start) begin
            acc     <= data_in;
            op_q    <= ctrl_op;
            shamt_q <= ctrl_shamt;
            k       <= KTop;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= StShift;
          end
        end
        StShift: begin
          acc <= stage_y;
          // Always run all five stages so latency is independent of shamt.
          if (k == 3'd0) begin
            result       <= stage_y;
            result_valid <= 1'b1;
            state        <= StDone;
          end else begin
            k <= k - 3'd1;
          end
        end
        StDone: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          busy         <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus reset and back-to-back sequences.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ctrl_op;
  logic [4:0]  ctrl_shamt;
  logic [31:0] data_in;
  logic        ready;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ctrl_op      (ctrl_op),
    .ctrl_shamt   (ctrl_shamt),
    .data_in      (data_in),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check({tag, "_ready_wait"}, 32'(ready), 32'd1);
  endtask

  // Drives one job from idle, checks hold, latency, result and return to idle.
  task automatic run_job(input vec_t v, input string tag);
    logic [31:0] prev;
    int cnt;
    wait_ready(tag);
    prev       = result;
    start      = 1'b1;
    ctrl_op    = v.op;
    ctrl_shamt = v.shamt;
    data_in    = v.data;
    @(negedge clock);
    start      = 1'b0;
    ctrl_op    = ~v.op;
    ctrl_shamt = ~v.shamt;
    data_in    = ~v.data;
    check({tag, "_acc_busy"}, 32'(busy), 32'd1);
    check({tag, "_acc_ready"}, 32'(ready), 32'd0);
    cnt = 0;
    while (!result_valid && cnt < 12) begin
      @(negedge clock);
      cnt++;
      if (!result_valid) check({tag, "_hold"}, result, prev);
    end
    check({tag, "_latency"}, 32'(cnt), 32'd5);
    check({tag, "_result"}, result, v.exp);
    @(negedge clock);
    check({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_result_kept"}, result, v.exp);
  endtask

  initial begin
    int va;
    int vb;
    int nconsec;
    logic pv;

    vecs[0] = '{1'b1, 5'd16, 32'h8000_0000, 32'hFFFF_8000};
    vecs[1] = '{1'b1, 5'd16, 32'h7FFF_0000, 32'h0000_7FFF};
    vecs[2] = '{1'b1, 5'd31, 32'hF000_0000, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000};
    vecs[4] = '{1'b0, 5'd4,  32'h1234_5678, 32'h2345_6780};
    vecs[5] = '{1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 5'd5,  32'h1234_5678, 32'h0091_A2B3};
    vecs[8] = '{1'b0, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_E000};
    vecs[9] = '{1'b1, 5'd1,  32'h8000_0001, 32'hC000_0000};

    reset      = 1'b1;
    start      = 1'b0;
    ctrl_op    = 1'b0;
    ctrl_shamt = 5'd0;
    data_in    = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_no_start", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of SHIFT (after E2).
    wait_ready("midrst");
    start      = 1'b1;
    ctrl_op    = 1'b0;
    ctrl_shamt = 5'd3;
    data_in    = 32'h0000_00FF;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_job(vecs[0], "postrst");

    // Back-to-back: start held high with job B while job A runs.
    wait_ready("b2b");
    start      = 1'b1;
    ctrl_op    = 1'b0;
    ctrl_shamt = 5'd1;
    data_in    = 32'h0000_0001;
    @(negedge clock);
    ctrl_op    = 1'b1;
    ctrl_shamt = 5'd4;
    data_in    = 32'h8000_0000;
    va = 0;
    vb = 0;
    nconsec = 0;
    pv = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (result_valid && pv) nconsec++;
      if (result_valid) begin
        if (va == 0) begin
          va = c;
          check("b2b_a_result", result, 32'h0000_0002);
        end else begin
          vb = c;
          check("b2b_b_result", result, 32'hF800_0000);
        end
      end
      if (c <= 5) check($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'd1);
      if (c == 6) check("b2b_ready_e6", 32'(ready), 32'd1);
      if (c == 7) begin
        check("b2b_accept_e7", 32'(busy), 32'd1);
        start = 1'b0;
      end
      pv = result_valid;
    end
    check("b2b_a_cycle", 32'(va), 32'd5);
    check("b2b_b_cycle", 32'(vb), 32'd12);
    check("b2b_no_consec", 32'(nconsec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
